vending_machine_param: RTL and testbench

//  Parametrised credit-based vending controller, next generation of the one-/two-unit chocolate FSM.
//  - Accepts coins of any value through a valid/ready port and accumulates credit.
//  - Vends through a held-request/ack handshake with the dispenser.
//  - Returns change or refunds on cancel, one unit pulse per cycle; counts completed sales.
//  - Sits between the coin acceptor and the dispenser / change hopper.

---
 rtl/vending_machine_param.sv | 140 ++++++++++++++
 tb/tb_vending_machine_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// ----------------------------------------------------------------------------
// vending_machine_param
// Credit-based vending controller. Coins of any value arrive through a
// valid/ready port and add to a credit register. Once credit reaches PRICE,
// the controller holds a vend request to the dispenser until the dispenser
// acknowledges. Change, or a refund on cancel, is then paid out one credit
// unit per cycle. Completed sales are counted with a saturating counter.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   coin_valid   coin present on coin_val
//   coin_val     coin value in credit units (0 = ignored)
//   coin_ready   controller can take a coin this cycle (combinational)
//   cancel       refund request for the current credit
//   choco_out    vend request, held until vend_ack
//   vend_ack     dispenser released the item
//   chng_out     one pulse per returned credit unit
//   coin_reject  one-cycle pulse: offered coin would overflow credit
//   credit       current credit
//   sales        completed vends, saturating
// ----------------------------------------------------------------------------
module vending_machine_param #(
   parameter int unsigned PRICE      = 3,
   parameter int unsigned VAL_W      = 4,
   parameter int unsigned CRED_W     = 5,
   parameter int unsigned MAX_CREDIT = 15,
   parameter int unsigned CNT_W      = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              coin_valid,
   input  logic [VAL_W-1:0]  coin_val,
   output logic              coin_ready,
   input  logic              cancel,
   output logic              choco_out,
   input  logic              vend_ack,
   output logic              chng_out,
   output logic              coin_reject,
   output logic [CRED_W-1:0] credit,
   output logic [CNT_W-1:0]  sales
);

   // Sum width holds the larger operand plus a carry, so it never wraps.
   localparam int unsigned SUM_W = ((CRED_W > VAL_W) ? CRED_W : VAL_W) + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_VEND    = 2'd2,
      S_CHANGE  = 2'd3
   } state_t;

   state_t              r_state;
   logic [CRED_W-1:0]   r_credit;
   logic [CNT_W-1:0]    r_sales;
   logic                r_reject;

   logic [SUM_W-1:0]    w_sum;
   logic                w_accept;
   logic                w_ovf;
   logic                w_reach;
   logic [CRED_W-1:0]   w_new;
   logic [CRED_W-1:0]   w_left;

   // Coin handshake and credit arithmetic
   assign coin_ready = ((r_state == S_IDLE) || (r_state == S_COLLECT)) && !cancel;
   assign w_accept   = coin_valid && coin_ready && (coin_val != '0);
   assign w_sum      = SUM_W'(r_credit) + SUM_W'(coin_val);
   assign w_ovf      = w_sum > SUM_W'(MAX_CREDIT);
   assign w_reach    = w_sum >= SUM_W'(PRICE);
   assign w_new      = CRED_W'(w_sum);
   // Credit is at least PRICE whenever VEND is entered.
   assign w_left     = r_credit - CRED_W'(PRICE);

   // State, credit, sales and reject pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_credit <= '0;
         r_sales  <= '0;
         r_reject <= 1'b0;
      end else begin
         r_reject <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_ovf) begin
                     r_reject <= 1'b1;
                  end else begin
                     r_credit <= w_new;
                     r_state  <= w_reach ? S_VEND : S_COLLECT;
                  end
               end
            end
            S_COLLECT: begin
               // Cancel deasserts coin_ready, so it always beats a coin.
               if (cancel) begin
                  r_state <= S_CHANGE;
               end else if (w_accept) begin
                  if (w_ovf) begin
                     r_reject <= 1'b1;
                  end else begin
                     r_credit <= w_new;
                     if (w_reach) r_state <= S_VEND;
                  end
               end
            end
            S_VEND: begin
               if (vend_ack) begin
                  r_credit <= w_left;
                  if (r_sales != '1) r_sales <= r_sales + CNT_W'(1);
                  r_state  <= (w_left != '0) ? S_CHANGE : S_IDLE;
               end
            end
            S_CHANGE: begin
               // The pulse that takes credit from 1 to 0 is the last one.
               if (r_credit <= CRED_W'(1)) begin
                  r_credit <= '0;
                  r_state  <= S_IDLE;
               end else begin
                  r_credit <= r_credit - CRED_W'(1);
               end
            end
            default: begin
               r_credit <= '0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decoded from registers only
   assign choco_out   = (r_state == S_VEND);
   assign chng_out    = (r_state == S_CHANGE);
   assign coin_reject = r_reject;
   assign credit      = r_credit;
   assign sales       = r_sales;

endmodule

// File: tb/tb_vending_machine_param.sv
// ----------------------------------------------------------------------------
// tb_vending_machine_param
// Directed bench for vending_machine_param (PRICE=3, MAX_CREDIT=15), plus a
// second instance with CNT_W=2 to exercise sales saturation.
// ----------------------------------------------------------------------------
module tb_vending_machine_param;

   logic       clk;
   logic       reset_n;
   logic       coin_valid;
   logic [3:0] coin_val;
   logic       coin_ready;
   logic       cancel;
   logic       choco_out;
   logic       vend_ack;
   logic       chng_out;
   logic       coin_reject;
   logic [4:0] credit;
   logic [7:0] sales;

   logic       s_coin_valid;
   logic [3:0] s_coin_val;
   logic       s_coin_ready;
   logic       s_cancel;
   logic       s_choco_out;
   logic       s_vend_ack;
   logic       s_chng_out;
   logic       s_coin_reject;
   logic [4:0] s_credit;
   logic [1:0] s_sales;

   int checks;
   int errors;

   vending_machine_param #(
      .PRICE(3), .VAL_W(4), .CRED_W(5), .MAX_CREDIT(15), .CNT_W(8)
   ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .coin_valid(coin_valid), .coin_val(coin_val), .coin_ready(coin_ready),
      .cancel(cancel), .choco_out(choco_out), .vend_ack(vend_ack),
      .chng_out(chng_out), .coin_reject(coin_reject),
      .credit(credit), .sales(sales)
   );

   vending_machine_param #(
      .PRICE(3), .VAL_W(4), .CRED_W(5), .MAX_CREDIT(15), .CNT_W(2)
   ) u_sat (
      .clk(clk), .reset_n(reset_n),
      .coin_valid(s_coin_valid), .coin_val(s_coin_val), .coin_ready(s_coin_ready),
      .cancel(s_cancel), .choco_out(s_choco_out), .vend_ack(s_vend_ack),
      .chng_out(s_chng_out), .coin_reject(s_coin_reject),
      .credit(s_credit), .sales(s_sales)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic coin(input logic [3:0] v);
      coin_valid = 1'b1;
      coin_val   = v;
   endtask

   task automatic no_coin();
      coin_valid = 1'b0;
      coin_val   = 4'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      coin_valid = 1'b0; coin_val = 4'd0; cancel = 1'b0; vend_ack = 1'b0;
      s_coin_valid = 1'b0; s_coin_val = 4'd0; s_cancel = 1'b0; s_vend_ack = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_credit", 32'(credit), 0);
      chk("rst_sales", 32'(sales), 0);
      chk("rst_choco", 32'(choco_out), 0);
      chk("rst_chng", 32'(chng_out), 0);
      chk("rst_reject", 32'(coin_reject), 0);
      chk("rst_ready", 32'(coin_ready), 1);
      reset_n = 1'b1;
      tick();

      // Coin 2 + coin 2 -> vend, one change pulse
      coin(4'd2); tick();
      chk("t1_credit2", 32'(credit), 2);
      chk("t1_choco_lo", 32'(choco_out), 0);
      coin(4'd2); tick();
      chk("t1_credit4", 32'(credit), 4);
      chk("t1_choco_hi", 32'(choco_out), 1);
      no_coin();
      chk("t1_ready_vend", 32'(coin_ready), 0);
      vend_ack = 1'b1; tick();
      vend_ack = 1'b0;
      chk("t1_choco_off", 32'(choco_out), 0);
      chk("t1_chng_pulse", 32'(chng_out), 1);
      chk("t1_credit1", 32'(credit), 1);
      chk("t1_sales", 32'(sales), 1);
      tick();
      chk("t1_chng_end", 32'(chng_out), 0);
      chk("t1_credit0", 32'(credit), 0);
      chk("t1_ready_idle", 32'(coin_ready), 1);

      // Coin 5 -> direct vend, ack in 4th cycle, two change pulses
      coin(4'd5); tick();
      no_coin();
      chk("t2_credit5", 32'(credit), 5);
      chk("t2_choco_c1", 32'(choco_out), 1);
      tick(); chk("t2_choco_c2", 32'(choco_out), 1);
      tick(); chk("t2_choco_c3", 32'(choco_out), 1);
      tick(); chk("t2_choco_c4", 32'(choco_out), 1);
      vend_ack = 1'b1; tick();
      vend_ack = 1'b0;
      chk("t2_choco_off", 32'(choco_out), 0);
      chk("t2_chng_p1", 32'(chng_out), 1);
      chk("t2_credit2", 32'(credit), 2);
      tick();
      chk("t2_chng_p2", 32'(chng_out), 1);
      chk("t2_credit1", 32'(credit), 1);
      tick();
      chk("t2_chng_end", 32'(chng_out), 0);
      chk("t2_credit0", 32'(credit), 0);
      chk("t2_sales", 32'(sales), 2);

      // Coin 1, coin 1, cancel -> two refund pulses
      coin(4'd1); tick();
      coin(4'd1); tick();
      no_coin();
      chk("t3_credit2", 32'(credit), 2);
      cancel = 1'b1;
      #1 chk("t3_ready_cancel", 32'(coin_ready), 0);
      tick();
      cancel = 1'b0;
      chk("t3_chng_p1", 32'(chng_out), 1);
      tick();
      chk("t3_chng_p2", 32'(chng_out), 1);
      chk("t3_credit1", 32'(credit), 1);
      tick();
      chk("t3_chng_end", 32'(chng_out), 0);
      chk("t3_credit0", 32'(credit), 0);
      chk("t3_choco", 32'(choco_out), 0);
      chk("t3_sales", 32'(sales), 2);

      // Zero-value coin and stray ack in IDLE are ignored
      coin(4'd0); vend_ack = 1'b1; tick();
      no_coin(); vend_ack = 1'b0;
      chk("t0_credit", 32'(credit), 0);
      chk("t0_reject", 32'(coin_reject), 0);
      chk("t0_sales", 32'(sales), 2);
      chk("t0_choco", 32'(choco_out), 0);

      // Overflow reject, then cancel beats a simultaneous coin
      coin(4'd2); tick();
      coin(4'd15); tick();
      no_coin();
      chk("t4_reject", 32'(coin_reject), 1);
      chk("t4_credit_kept", 32'(credit), 2);
      tick();
      chk("t4_reject_end", 32'(coin_reject), 0);
      coin(4'd1); cancel = 1'b1; tick();
      no_coin(); cancel = 1'b0;
      chk("t4_credit_nocoin", 32'(credit), 2);
      chk("t4_chng_p1", 32'(chng_out), 1);
      tick();
      chk("t4_chng_p2", 32'(chng_out), 1);
      tick();
      chk("t4_chng_end", 32'(chng_out), 0);
      chk("t4_credit0", 32'(credit), 0);

      // Reset during CHANGE with credit 3
      coin(4'd6); tick();
      no_coin();
      vend_ack = 1'b1; tick();
      vend_ack = 1'b0;
      chk("t5_chng", 32'(chng_out), 1);
      chk("t5_credit3", 32'(credit), 3);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_chng", 32'(chng_out), 0);
      chk("t5_rst_credit", 32'(credit), 0);
      chk("t5_rst_choco", 32'(choco_out), 0);
      chk("t5_rst_sales", 32'(sales), 0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5_no_pulse", 32'(chng_out), 0);
      end

      // CNT_W=2 instance: sales saturates at 3 after 5 vends
      for (int i = 0; i < 5; i++) begin
         s_coin_valid = 1'b1; s_coin_val = 4'd3; tick();
         s_coin_valid = 1'b0; s_coin_val = 4'd0;
         chk("t6_choco", 32'(s_choco_out), 1);
         s_vend_ack = 1'b1; tick();
         s_vend_ack = 1'b0;
         chk("t6_sales", 32'(s_sales), (i < 3) ? (i + 1) : 3);
      end
      chk("t6_credit0", 32'(s_credit), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
